// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and the parity helper used when a word is loaded into the shifter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake and line signals between the slow-control response logic
// (master) and the UART transmitter (slave).
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// o_Wrap during the final cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int CNT_W        = 16
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Wrap
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_reg <= '0;
    end else if (i_Clear) begin
      cnt_reg <= '0;
    end else if (i_Enable) begin
      cnt_reg <= (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign o_Wrap = i_Enable && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start / LSB-first data / optional parity / stop bits,
// with a one-word holding register so frames can run back to back.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1302,
  parameter int CNT_W        = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_tx_frame_if.slave   tx
);
  localparam bit         PAR_EN        = (PARITY_MODE != PARITY_NONE);
  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

  tx_state_e            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] hold_reg, hold_next;
  logic                 hold_full_reg, hold_full_next;
  logic                 parity_reg, parity_next;
  logic [3:0]           idx_reg, idx_next;
  logic                 serial_reg, serial_next;
  logic                 active_reg, active_next;
  logic                 done_reg, done_next;
  logic                 ready_reg, ready_next;
  logic                 load_new;
  logic [DATA_BITS-1:0] load_word;
  logic                 bit_wrap;
  logic                 accept;
  logic                 frame_end;

  assign accept    = tx.i_Tx_DV && !hold_full_reg;
  assign frame_end = (state_reg == ST_STOP) && bit_wrap && (idx_reg == LAST_STOP_IDX);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (state_reg == ST_IDLE),
    .i_Enable (state_reg != ST_IDLE),
    .o_Wrap   (bit_wrap)
  );

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    parity_next    = parity_reg;
    idx_next       = idx_reg;
    serial_next    = serial_reg;
    active_next    = active_reg;
    done_next      = 1'b0;
    load_new       = 1'b0;
    load_word      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          load_new  = 1'b1;
          load_word = tx.i_Tx_Byte;
        end
      end
      ST_START: begin
        if (bit_wrap) begin
          state_next  = ST_DATA;
          idx_next    = '0;
          serial_next = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_wrap) begin
          if (idx_reg == LAST_DATA_IDX) begin
            idx_next = '0;
            if (PAR_EN) begin
              state_next  = ST_PARITY;
              serial_next = parity_reg;
            end else begin
              state_next  = ST_STOP;
              serial_next = 1'b1;
            end
          end else begin
            idx_next    = idx_reg + 1'b1;
            shift_next  = shift_reg >> 1;
            serial_next = shift_reg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_wrap) begin
          state_next  = ST_STOP;
          idx_next    = '0;
          serial_next = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_wrap) begin
          if (idx_reg == LAST_STOP_IDX) begin
            done_next = 1'b1;
            // A waiting word wins; otherwise a word offered right now starts directly.
            if (hold_full_reg) begin
              load_new       = 1'b1;
              load_word      = hold_reg;
              hold_full_next = 1'b0;
            end else if (accept) begin
              load_new  = 1'b1;
              load_word = tx.i_Tx_Byte;
            end else begin
              state_next  = ST_IDLE;
              serial_next = 1'b1;
              active_next = 1'b0;
            end
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end
    endcase

    if (accept && (state_reg != ST_IDLE) && !frame_end) begin
      hold_next      = tx.i_Tx_Byte;
      hold_full_next = 1'b1;
    end

    if (load_new) begin
      state_next  = ST_START;
      shift_next  = load_word;
      parity_next = parity_bit(MAX_DATA_BITS'(load_word), PARITY_MODE);
      idx_next    = '0;
      serial_next = 1'b0;
      active_next = 1'b1;
    end

    ready_next = !hold_full_next;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      parity_reg    <= 1'b0;
      idx_reg       <= '0;
      serial_reg    <= 1'b1;
      active_reg    <= 1'b0;
      done_reg      <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      parity_reg    <= parity_next;
      idx_reg       <= idx_next;
      serial_reg    <= serial_next;
      active_reg    <= active_next;
      done_reg      <= done_next;
      ready_reg     <= ready_next;
    end
  end

  assign tx.o_Tx_Serial = serial_reg;
  assign tx.o_Tx_Active = active_reg;
  assign tx.o_Tx_Done   = done_reg;
  assign tx.o_Tx_Ready  = ready_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E2, 8O1) at 4 clocks/bit,
// checked each cycle against a per-cycle line schedule plus literal frame pins.
module tb_uart_tx_frame;
  localparam int NI  = 3;
  localparam int CPB = 4;
  localparam int DB [NI] = '{8, 7, 8};
  localparam int PM [NI] = '{0, 2, 1};
  localparam int SB [NI] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tb_dv   [NI];
  logic [8:0] tb_byte [NI];
  logic [NI-1:0] dut_serial, dut_active, dut_done, dut_ready;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = DB[gi];
    uart_tx_frame_if #(.DATA_BITS(W)) bus ();
    assign bus.i_Tx_DV     = tb_dv[gi];
    assign bus.i_Tx_Byte   = tb_byte[gi][W-1:0];
    assign dut_serial[gi]  = bus.o_Tx_Serial;
    assign dut_active[gi]  = bus.o_Tx_Active;
    assign dut_done[gi]    = bus.o_Tx_Done;
    assign dut_ready[gi]   = bus.o_Tx_Ready;
    uart_tx_frame #(
      .CLKS_PER_BIT (CPB),
      .CNT_W        (16),
      .DATA_BITS    (W),
      .PARITY_MODE  (PM[gi]),
      .STOP_BITS    (SB[gi])
    ) u_dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .tx      (bus)
    );
  end

  // Model: every accepted word appends its whole frame, one entry per clock, to a line queue.
  bit   line_q [NI][$];
  bit   last_q [NI][$];
  int   nfr      [NI];
  bit   cur_last [NI];
  logic exp_serial [NI];
  logic exp_active [NI];
  logic exp_done   [NI];
  logic exp_ready  [NI];

  task automatic model_push(input int i, input logic [8:0] w);
    bit b[$];
    int ones;
    ones = 0;
    b.push_back(1'b0);
    for (int d = 0; d < DB[i]; d++) begin
      b.push_back(w[d]);
      ones += int'(w[d]);
    end
    if (PM[i] == 1) b.push_back(ones % 2 == 0);
    else if (PM[i] == 2) b.push_back(ones % 2 == 1);
    for (int s = 0; s < SB[i]; s++) b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++)
      for (int c = 0; c < CPB; c++) begin
        line_q[i].push_back(b[j]);
        last_q[i].push_back(j == b.size() - 1 && c == CPB - 1);
      end
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < NI; i++) begin
      nfr[i] = 0; cur_last[i] = 0;
      exp_serial[i] = 1'b1; exp_active[i] = 1'b0; exp_done[i] = 1'b0; exp_ready[i] = 1'b1;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          line_q[i].delete(); last_q[i].delete();
          nfr[i] = 0; cur_last[i] = 0;
          exp_serial[i] = 1'b1; exp_active[i] = 1'b0; exp_done[i] = 1'b0; exp_ready[i] = 1'b1;
        end else begin
          acc = tb_dv[i] && exp_ready[i];
          exp_done[i] = cur_last[i];
          if (cur_last[i]) begin
            nfr[i]--;
            $display("inst%0d: frame complete at %0t", i, $time);
          end
          if (acc) begin
            model_push(i, tb_byte[i]);
            nfr[i]++;
          end
          if (line_q[i].size() != 0) begin
            exp_serial[i] = line_q[i].pop_front();
            cur_last[i]   = last_q[i].pop_front();
            exp_active[i] = 1'b1;
          end else begin
            exp_serial[i] = 1'b1;
            cur_last[i]   = 1'b0;
            exp_active[i] = 1'b0;
          end
          exp_ready[i] = (nfr[i] <= 1);
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("serial%0d", i), dut_serial[i], exp_serial[i]);
      chk($sformatf("active%0d", i), dut_active[i], exp_active[i]);
      chk($sformatf("done%0d", i),   dut_done[i],   exp_done[i]);
      chk($sformatf("ready%0d", i),  dut_ready[i],  exp_ready[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Sends one word to an idle instance and checks the frame against literal bits (LSB = start bit).
  task automatic pin_frame(input int i, input logic [8:0] w, input logic [11:0] bits, input int nb);
    tb_dv[i] = 1'b1; tb_byte[i] = w;
    tick();
    tb_dv[i] = 1'b0;
    for (int k = 0; k <= nb * CPB + 1; k++) begin
      if (k > 0) tick();
      if (k < nb * CPB) begin
        chk($sformatf("pin%0d_serial_k%0d", i, k), dut_serial[i], bits[k / CPB]);
        chk($sformatf("pin%0d_active_k%0d", i, k), dut_active[i], 1'b1);
      end else if (k == nb * CPB) begin
        chk($sformatf("pin%0d_done_end", i),   dut_done[i],   1'b1);
        chk($sformatf("pin%0d_active_end", i), dut_active[i], 1'b0);
        chk($sformatf("pin%0d_serial_end", i), dut_serial[i], 1'b1);
      end else begin
        chk($sformatf("pin%0d_done_after", i), dut_done[i], 1'b0);
      end
    end
    $display("inst%0d: pinned frame word 0x%0h", i, w);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      tb_dv[i] = 1'b0; tb_byte[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_serial%0d", i), dut_serial[i], 1'b1);
      chk($sformatf("rst_active%0d", i), dut_active[i], 1'b0);
      chk($sformatf("rst_done%0d", i),   dut_done[i],   1'b0);
      chk($sformatf("rst_ready%0d", i),  dut_ready[i],  1'b1);
    end
    rst = 1'b0;
    repeat (2) tick();

    pin_frame(0, 9'h0A5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
    pin_frame(1, 9'h053, {1'b0, 2'b11, 1'b0, 7'h53, 1'b0}, 11);
    pin_frame(2, 9'h0FF, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11);

    // Back-to-back: 0x01 at E0, 0x80 at E0+5, 0x55 at E0+10 must be dropped.
    tb_dv[0] = 1'b1; tb_byte[0] = 9'h001;
    tick();
    tb_dv[0] = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 5)  chk("b2b_ready_low", dut_ready[0], 1'b0);
      if (k == 10) chk("b2b_ready_still_low", dut_ready[0], 1'b0);
      if (k == 40) begin
        chk("b2b_done40",   dut_done[0],   1'b1);
        chk("b2b_active40", dut_active[0], 1'b1);
        chk("b2b_serial40", dut_serial[0], 1'b0);
        chk("b2b_ready40",  dut_ready[0],  1'b1);
      end
      if (k == 68) chk("b2b_bit6", dut_serial[0], 1'b0);
      if (k == 72) chk("b2b_bit7", dut_serial[0], 1'b1);
      if (k == 80) begin
        chk("b2b_done80",   dut_done[0],   1'b1);
        chk("b2b_active80", dut_active[0], 1'b0);
      end
      if (k > 80) chk("b2b_no_third", dut_active[0], 1'b0);
      tb_dv[0]   = (k == 4 || k == 9);
      tb_byte[0] = (k == 4) ? 9'h080 : 9'h055;
    end
    tb_dv[0] = 1'b0;
    $display("inst0: back-to-back sequence done");

    // Accept on the end-of-frame edge with the holding register empty.
    tb_dv[0] = 1'b1; tb_byte[0] = 9'h03C;
    tick();
    tb_dv[0] = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 39) chk("coin_stop39", dut_serial[0], 1'b1);
      if (k == 40) begin
        chk("coin_done40",   dut_done[0],   1'b1);
        chk("coin_serial40", dut_serial[0], 1'b0);
        chk("coin_active40", dut_active[0], 1'b1);
      end
      if (k == 44) chk("coin_bit0", dut_serial[0], 1'b1);
      tb_dv[0]   = (k == 39);
      tb_byte[0] = 9'h0C3;
    end
    tb_dv[0] = 1'b0;
    $display("inst0: coincident accept sequence done");

    // Reset during data bit 3 with a word waiting in the holding register.
    tb_dv[0] = 1'b1; tb_byte[0] = 9'h0F0;
    tick();
    tb_dv[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      tb_dv[0]   = (k == 3);
      tb_byte[0] = 9'h055;
    end
    tb_dv[0] = 1'b0;
    chk("rstmid_ready_before", dut_ready[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_serial", dut_serial[0], 1'b1);
    chk("rstmid_active", dut_active[0], 1'b0);
    chk("rstmid_ready",  dut_ready[0],  1'b1);
    chk("rstmid_done",   dut_done[0],   1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rstmid_no_resume", dut_active[0], 1'b0);
    pin_frame(0, 9'h03C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);

    // Randomised traffic: alternate dense and sparse offers, one mid-run reset.
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (c == 1000) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
      for (int i = 0; i < NI; i++) begin
        tb_dv[i]   = ((c / 200) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
        tb_byte[i] = 9'($urandom);
      end
    end
    for (int i = 0; i < NI; i++) tb_dv[i] = 1'b0;
    repeat (150) tick();
    for (int i = 0; i < NI; i++) chk($sformatf("drain_idle%0d", i), dut_active[i], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the slow-control serial path. It serialises one word per frame with a compile-time configurable data width, parity mode and stop-bit count. A one-word holding register allows back-to-back frames with no idle gap, and the valid/ready handshake replaces fire-and-forget strobing. It drives the board TX pin directly and is fed by the slow-control response logic.

## Interface
- CLKS_PER_BIT, 1302: clock cycles per bit (50 MHz / 38 400 baud); legal range 2 to 2^CNT_W−1.
- CNT_W, 16: bit-timer counter width.
- DATA_BITS, 8: payload bits per frame; legal range 5–9.
- PARITY_MODE, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- i_Clock  in  1  sole clock; all logic is on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  word valid; accepted when i_Tx_DV && o_Tx_Ready at a clock edge.
- i_Tx_Byte  in  DATA_BITS  payload, transmitted LSB first.
- o_Tx_Ready  out  1  high when the holding register is empty.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Serial  out  1  TX line; idles high.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE=0.
- Frame bits: F = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS. The frame lasts F×CLKS_PER_BIT cycles.
- Start bit is 0. Data bits follow LSB first. Parity bit is ^data for even and ~^data for odd. Stop bits are 1.
- Each bit is held for exactly CLKS_PER_BIT cycles, timed by a counter running 0..CLKS_PER_BIT−1. The bit index steps on counter wrap.
- Accept in IDLE: the word loads directly into the shift register and the FSM enters START. The holding register stays empty and o_Tx_Ready stays high.
- Accept while not in IDLE: the word is stored in the holding register and o_Tx_Ready goes low.
- End of the last stop bit with the holding register full: the held word moves to the shifter and START begins on the same edge, with no idle cycle. o_Tx_Ready returns high.
- End of the last stop bit with the holding register empty: the FSM goes to IDLE.
- Accept in the same cycle as end-of-frame with the holding register empty: the word is treated as a direct load and starts the next frame immediately.
- i_Tx_DV while o_Tx_Ready is low is ignored. The word is dropped and nothing in flight changes.
- i_Tx_Byte is sampled only on the accept edge.

## Timing
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. FSM goes to IDLE; counter, index and holding register are cleared. All outputs change immediately on assertion, without waiting for a clock.
- Reset mid-frame aborts the frame: the line returns high immediately and no Done pulse is produced.
- Let E0 be the accept edge of a word that starts a frame.
  - From E0: o_Tx_Serial=0 and o_Tx_Active=1, i.e. one-edge latency.
  - At E0+F×CLKS_PER_BIT: o_Tx_Done=1 for exactly one cycle.
  - At that same edge, o_Tx_Active falls, unless a back-to-back frame starts, in which case it stays high continuously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - state encoding;
  - PARITY_NONE/ODD/EVEN constants;
  - a parity function (data, mode) → bit.
- One sub-module, uart_bit_timer: CNT_W counter with load/clear and a one-cycle wrap strobe at CLKS_PER_BIT−1.
- uart_tx_frame contains the FSM, shift register, bit index and holding register.

## Test plan
All cases use CLKS_PER_BIT=4.

- 8N1, 0xA5 accepted at E0:
  - serial is 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles;
  - Done pulses at E0+40 and Active falls at E0+40.
- 7E2, 0x53 (four ones):
  - parity bit is 0 and the frame is 44 cycles;
  - 8O1, 0xFF: parity bit is 1 and the frame is 44 cycles.
- Back-to-back, 8N1:
  - 0x01 at E0, then 0x80 at E0+5: Ready goes low at E0+5, and a third DV at E0+10 is ignored;
  - at E0+40: Done pulses, Active stays high, serial=0 (next start bit) and Ready goes high;
  - 0x80 completes at E0+80;
  - no 0x55 frame ever appears.
- Accept coinciding with end-of-frame (E0+40) with the holding register empty: the next start bit begins at E0+40, with no high cycle between frames.
- Reset pulse in DATA bit 3:
  - serial is 1, Active is 0, Ready is 1 immediately, with no Done pulse;
  - after release, 0x3C transmits correctly.
